bus_responder: RTL and testbench

- Target side of the CPU external bus: answers bus cycles issued by the CPU core (strobe, write-enable, address, write data) with read data and a data-ready acknowledge.
- Decodes a fixed address window and maps it onto a small register bank: ID, two scratch registers, a loadable free-running counter, and a sticky status register.
- Sits on the system bus beside other peripherals; addresses outside the window are left unanswered for other targets.

---
 rtl/bus_responder_pkg.sv | 39 +++
 rtl/bus_responder_regs.sv | 62 ++++++
 rtl/bus_responder.sv | 75 +++++++
 tb/tb_bus_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared register map, status bits, FSM states and request record for the
// CPU external-bus target.
`ifndef BUS_RESPONDER_DW
`define BUS_RESPONDER_DW 32
`endif

package bus_responder_pkg;

  localparam logic [4:0] OFF_ID       = 5'h00;
  localparam logic [4:0] OFF_SCRATCH0 = 5'h04;
  localparam logic [4:0] OFF_SCRATCH1 = 5'h08;
  localparam logic [4:0] OFF_COUNTER  = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // Word indices as seen on addr[4:2]
  localparam logic [2:0] IDX_ID       = OFF_ID[4:2];
  localparam logic [2:0] IDX_SCRATCH0 = OFF_SCRATCH0[4:2];
  localparam logic [2:0] IDX_SCRATCH1 = OFF_SCRATCH1[4:2];
  localparam logic [2:0] IDX_COUNTER  = OFF_COUNTER[4:2];
  localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];

  localparam int ST_WR_RO   = 0;
  localparam int ST_WR_RSVD = 1;
  localparam int ST_BITS    = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic                         we;
    logic [2:0]                   idx;
    logic [`BUS_RESPONDER_DW-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/bus_responder_regs.sv
// Register bank behind the bus target: ID, two scratch words, free-running
// loadable counter, sticky W1C status and the read mux.
module bus_responder_regs
  import bus_responder_pkg::*;
#(
  parameter logic [`BUS_RESPONDER_DW-1:0] ID_VALUE = 32'h6583_2001
) (
  input  logic                         i_cpu_clk,
  input  logic                         i_rst_n,
  input  logic                         wr_en,
  input  logic [2:0]                   idx,
  input  logic [`BUS_RESPONDER_DW-1:0] wdata,
  output logic [`BUS_RESPONDER_DW-1:0] rdata,
  output logic                         irq
);

  logic [`BUS_RESPONDER_DW-1:0] scratch0, scratch1, counter;
  logic [ST_BITS-1:0]           status, st_set, st_clr;

  always_comb begin
    st_set = '0;
    st_clr = '0;
    if (wr_en) begin
      case (idx)
        IDX_ID:                                 st_set[ST_WR_RO] = 1'b1;
        IDX_SCRATCH0, IDX_SCRATCH1, IDX_COUNTER: st_clr = '0;
        IDX_STATUS:                             st_clr = wdata[ST_BITS-1:0];
        default:                                st_set[ST_WR_RSVD] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scratch0 <= '0;
      scratch1 <= '0;
      counter  <= '0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && idx == IDX_SCRATCH0) scratch0 <= wdata;
      if (wr_en && idx == IDX_SCRATCH1) scratch1 <= wdata;
      counter <= (wr_en && idx == IDX_COUNTER) ? wdata : counter + 1'b1;
      // Set is applied after clear so a coincident event wins
      status  <= (status & ~st_clr) | st_set;
      irq     <= |status;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_ID:       rdata = ID_VALUE;
      IDX_SCRATCH0: rdata = scratch0;
      IDX_SCRATCH1: rdata = scratch1;
      IDX_COUNTER:  rdata = counter;
      IDX_STATUS:   rdata = {{(`BUS_RESPONDER_DW-ST_BITS){1'b0}}, status};
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/bus_responder.sv
// CPU external-bus target: window decode plus IDLE/WAIT/ACK/RELEASE handshake
// around the register bank.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [`BUS_RESPONDER_DW-1:0] BASE_ADDR   = 32'h0000_F000,
  parameter int                           WAIT_STATES = 2,
  parameter logic [`BUS_RESPONDER_DW-1:0] ID_VALUE    = 32'h6583_2001
) (
  input  logic                         i_cpu_clk,
  input  logic                         i_rst_n,
  input  logic                         i_bus_clk,
  input  logic                         i_bus_we,
  input  logic [`BUS_RESPONDER_DW-1:0] i_bus_addr,
  input  logic [`BUS_RESPONDER_DW-1:0] i_bus_data,
  output logic [`BUS_RESPONDER_DW-1:0] o_bus_data,
  output logic                         o_bus_data_ready,
  output logic                         o_irq
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                       state;
  bus_req_t                     req;
  logic [3:0]                   wcnt;
  logic                         hit;
  logic [`BUS_RESPONDER_DW-1:0] rdata;
  logic                         unused_byte_lanes;

  assign hit = (i_bus_addr[31:5] == BASE_ADDR[31:5]);
  // Word-granular target: byte lanes do not select anything
  assign unused_byte_lanes = ^i_bus_addr[1:0];

  always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      req              <= '0;
      wcnt             <= '0;
      o_bus_data       <= '0;
      o_bus_data_ready <= 1'b0;
    end else begin
      o_bus_data_ready <= 1'b0;
      o_bus_data       <= '0;
      case (state)
        S_IDLE: if (i_bus_clk && hit) begin
          req   <= '{we: i_bus_we, idx: i_bus_addr[4:2], data: i_bus_data};
          wcnt  <= WS_LOAD;
          state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_ACK;
          else              wcnt  <= wcnt - 4'd1;
        end
        S_ACK: begin
          o_bus_data_ready <= 1'b1;
          o_bus_data       <= req.we ? '0 : rdata;
          state            <= S_RELEASE;
        end
        S_RELEASE: if (!i_bus_clk) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  bus_responder_regs #(.ID_VALUE(ID_VALUE)) u_regs (
    .i_cpu_clk (i_cpu_clk),
    .i_rst_n   (i_rst_n),
    .wr_en     ((state == S_ACK) && req.we),
    .idx       (req.idx),
    .wdata     (req.data),
    .rdata     (rdata),
    .irq       (o_irq)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with a transaction-level reference model.
module tb_bus_responder;

  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'h0000_F000;
  localparam logic [31:0] IDV  = 32'h6583_2001;

  logic        clk = 1'b0, rst_n = 1'b1, bclk = 1'b0, bwe = 1'b0;
  logic [31:0] baddr = '0, bdata = '0;
  logic [31:0] odata, odata0;
  logic        ordy, ordy0, oirq, oirq0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .ID_VALUE(IDV)) dut (
    .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(bclk), .i_bus_we(bwe),
    .i_bus_addr(baddr), .i_bus_data(bdata),
    .o_bus_data(odata), .o_bus_data_ready(ordy), .o_irq(oirq));

  bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(IDV)) dut0 (
    .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(bclk), .i_bus_we(bwe),
    .i_bus_addr(baddr), .i_bus_data(bdata),
    .o_bus_data(odata0), .o_bus_data_ready(ordy0), .o_irq(oirq0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model for dut: register contents and an outstanding transaction
  logic [31:0] m_s0 = '0, m_s1 = '0, m_cnt = '0, m_nc, t_data;
  logic [1:0]  m_st = '0, m_set, m_clr;
  logic        m_irq = 1'b0, e_rdy = 1'b0, busy = 1'b0, need_low = 1'b0, t_we;
  logic [31:0] e_data = '0;
  logic [2:0]  t_idx;
  int          edge_n = 0, due_edge = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s0 = '0; m_s1 = '0; m_cnt = '0; m_st = '0; m_irq = 1'b0;
      e_rdy = 1'b0; e_data = '0; busy = 1'b0; need_low = 1'b0;
    end else begin
      edge_n++;
      m_nc = m_cnt + 32'd1; m_set = '0; m_clr = '0;
      e_rdy = 1'b0; e_data = '0;
      if (busy) begin
        if (edge_n == due_edge) begin
          busy = 1'b0; need_low = 1'b1; e_rdy = 1'b1;
          if (t_we) begin
            case (t_idx)
              3'd0: m_set[0] = 1'b1;
              3'd1: m_s0 = t_data;
              3'd2: m_s1 = t_data;
              3'd3: m_nc = t_data;
              3'd4: m_clr = t_data[1:0];
              default: m_set[1] = 1'b1;
            endcase
          end else begin
            case (t_idx)
              3'd0: e_data = IDV;
              3'd1: e_data = m_s0;
              3'd2: e_data = m_s1;
              3'd3: e_data = m_cnt;
              3'd4: e_data = {30'd0, m_st};
              default: e_data = '0;
            endcase
          end
        end
      end else if (need_low) begin
        if (!bclk) need_low = 1'b0;
      end else if (bclk && baddr >= BASE && baddr < BASE + 32'd32) begin
        busy = 1'b1; due_edge = edge_n + WS + 1;
        t_we = bwe; t_idx = baddr[4:2]; t_data = bdata;
      end
      m_irq = |m_st;
      m_st  = (m_st & ~m_clr) | m_set;
      m_cnt = m_nc;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("cyc_ready", 32'(ordy), 32'(e_rdy));
    check("cyc_data", odata, e_data);
    check("cyc_irq", 32'(oirq), 32'(m_irq));
  end

  // mode 0: normal, 1: drop strobe after sample, 2: change bus during WAIT
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input int mode,
                      output logic [31:0] rd, output logic [31:0] rd0,
                      output int lat, output int lat0, output int pulses, output int pulses0);
    @(negedge clk);
    bclk = 1'b1; bwe = we; baddr = a; bdata = d;
    lat = -1; lat0 = -1; pulses = 0; pulses0 = 0; rd = '0; rd0 = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ordy) begin pulses++; if (lat < 0) begin lat = k; rd = odata; end end
      if (ordy0) begin pulses0++; if (lat0 < 0) begin lat0 = k; rd0 = odata0; end end
      if (lat >= 0 && k >= lat + hold) break;
      if (k == 0 && mode == 1) begin @(negedge clk); bclk = 1'b0; end
      if (k == 0 && mode == 2) begin
        @(negedge clk); baddr = BASE + 32'h8; bdata = 32'h5555_5555; bwe = 1'b0;
      end
    end
    @(negedge clk);
    bclk = 1'b0; bwe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r, r0; int l, l0, p, p0;
    xact(1'b1, a, d, 0, 0, r, r0, l, l0, p, p0);
    check("wr_latency", 32'(l), 32'd3);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r, r0; int l, l0, p, p0;
    xact(1'b0, a, '0, 0, 0, r, r0, l, l0, p, p0);
    check(nm, r, exp);
    check("rd_latency", 32'(l), 32'd3);
  endtask

  initial begin
    logic [31:0] r, r0; int l, l0, p, p0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", 32'(ordy), 32'd0);
    check("reset_data", odata, 32'd0);
    check("reset_irq", 32'(oirq), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ID read: WS=2 acks 3 cycles after sampling, WS=0 acks 1 cycle after
    xact(1'b0, 32'h0000_F000, '0, 0, 0, r, r0, l, l0, p, p0);
    check("id_data", r, 32'h6583_2001);
    check("id_latency", 32'(l), 32'd3);
    check("id_data_ws0", r0, 32'h6583_2001);
    check("id_latency_ws0", 32'(l0), 32'd1);
    @(posedge clk); #1;
    check("data_clears", odata, 32'd0);

    wr(32'h0000_F004, 32'hDEAD_BEEF);
    rd("scratch0_rt", 32'h0000_F004, 32'hDEAD_BEEF);
    rd("scratch0_unaligned", 32'h0000_F006, 32'hDEAD_BEEF);

    // Loaded value shows in the write's ready cycle; the read's ACK cycle
    // is 4 cycles later, so FFFFFFFE+4 wraps to 2
    wr(32'h0000_F00C, 32'hFFFF_FFFE);
    rd("counter_wrap", 32'h0000_F00C, 32'h0000_0002);
    wr(32'h0000_F00C, 32'h0000_0010);
    rd("counter_load", 32'h0000_F00C, 32'h0000_0014);

    wr(32'h0000_F000, 32'h1);
    @(posedge clk); #1;
    check("irq_set", 32'(oirq), 32'd1);
    rd("status_ro", 32'h0000_F010, 32'h1);
    wr(32'h0000_F014, 32'h1);
    rd("status_both", 32'h0000_F010, 32'h3);
    rd("status_nondestr", 32'h0000_F010, 32'h3);
    rd("rsvd_reads_0", 32'h0000_F014, 32'h0);
    rd("id_readonly", 32'h0000_F000, 32'h6583_2001);
    wr(32'h0000_F010, 32'h1);
    rd("status_w1c", 32'h0000_F010, 32'h2);
    check("irq_still", 32'(oirq), 32'd1);
    wr(32'h0000_F010, 32'h2);
    @(posedge clk); #1;
    check("irq_clear", 32'(oirq), 32'd0);
    rd("status_zero", 32'h0000_F010, 32'h0);

    // Misses: below and just above the window
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bclk = 1'b1; bwe = 1'b0; baddr = (i == 0) ? 32'h0000_E000 : 32'h0000_F020;
      p = 0;
      repeat (20) begin @(posedge clk); #1; if (ordy || ordy0) p++; end
      check("miss_no_ready", 32'(p), 32'd0);
      @(negedge clk); bclk = 1'b0;
    end

    xact(1'b0, 32'h0000_F004, '0, 5, 0, r, r0, l, l0, p, p0);
    check("hold_one_pulse", 32'(p), 32'd1);
    check("hold_one_pulse_ws0", 32'(p0), 32'd1);

    xact(1'b0, 32'h0000_F000, '0, 0, 1, r, r0, l, l0, p, p0);
    check("drop_latency", 32'(l), 32'd3);
    check("drop_data", r, 32'h6583_2001);
    rd("after_drop", 32'h0000_F004, 32'hDEAD_BEEF);

    // Reset while dut0 is acking and dut is still waiting
    @(negedge clk);
    bclk = 1'b1; bwe = 1'b1; baddr = 32'h0000_F008; bdata = 32'h0000_1234;
    @(posedge clk);
    @(posedge clk); #3;
    check("pre_rst_ready_ws0", 32'(ordy0), 32'd1);
    rst_n = 1'b0; #1;
    check("rst_ready", 32'(ordy), 32'd0);
    check("rst_ready_ws0", 32'(ordy0), 32'd0);
    check("rst_irq", 32'(oirq0), 32'd0);
    @(negedge clk); bclk = 1'b0; bwe = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd("scratch1_after_rst", 32'h0000_F008, 32'h0);
    rd("scratch0_after_rst", 32'h0000_F004, 32'h0);

    // Bus changes during WAIT must not affect the captured write
    xact(1'b1, 32'h0000_F004, 32'hAAAA_0000, 0, 2, r, r0, l, l0, p, p0);
    rd("capture_target", 32'h0000_F004, 32'hAAAA_0000);
    rd("capture_other", 32'h0000_F008, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
